// File: rtl/wb_select_stage.sv
// wb_select_stage: registered writeback-select stage feeding the register file.
//
// Selects the write data from one of four sources (ALU, load data, PC+4,
// immediate), extends byte/half loads, and waits on a variable-latency memory
// response before writing. All outputs are registered.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid        writeback request valid this cycle
//   wb_sel          source select: 0=ALU 1=MEM 2=PC+4 3=IMM
//   alu_result      ALU result
//   pc_plus4        link value
//   imm             immediate
//   rd_addr         destination register
//   reg_write       request actually writes the register file
//   load_size       0=byte 1=half 2,3=word
//   load_unsigned   1=zero-extend, 0=sign-extend
//   byte_off        load address bits [1:0]
//   mem_rdata       memory read data
//   mem_rvalid      mem_rdata valid this cycle
//   flush           abort pending/incoming request
//   rf_we           register-file write enable
//   rf_waddr        register-file write address
//   rf_wdata        register-file write data
//   stall           high while waiting on memory
//   err             one-cycle pulse on load timeout
module wb_select_stage #(
    parameter int unsigned W       = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [1:0]    wb_sel,
    input  logic [W-1:0]  alu_result,
    input  logic [W-1:0]  pc_plus4,
    input  logic [W-1:0]  imm,
    input  logic [AW-1:0] rd_addr,
    input  logic          reg_write,
    input  logic [1:0]    load_size,
    input  logic          load_unsigned,
    input  logic [1:0]    byte_off,
    input  logic [W-1:0]  mem_rdata,
    input  logic          mem_rvalid,
    input  logic          flush,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [W-1:0]  rf_wdata,
    output logic          stall,
    output logic          err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   lat_rd_q, lat_rd_d;
    logic            lat_rw_q, lat_rw_d;
    logic [1:0]      lat_size_q, lat_size_d;
    logic            lat_uns_q, lat_uns_d;
    logic [1:0]      lat_off_q, lat_off_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [W-1:0]    rf_wdata_q, rf_wdata_d;
    logic            err_q, err_d;

    // Extension works on the low 32 bits only; upper bits of wider buses are
    // filled with the extension bit.
    function automatic logic [W-1:0] load_ext(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  off);
        logic [7:0]   b;
        logic [15:0]  h;
        logic [W-1:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0: begin
                r       = {W{~uns & b[7]}};
                r[7:0]  = b;
            end
            2'd1: begin
                r       = {W{~uns & h[15]}};
                r[15:0] = h;
            end
            default: begin
                r       = {W{~uns & word[31]}};
                r[31:0] = word;
            end
        endcase
        return r;
    endfunction

    logic [W-1:0] src_data;

    always_comb begin
        case (wb_sel)
            2'd2:    src_data = pc_plus4;
            2'd3:    src_data = imm;
            default: src_data = alu_result;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_rd_d   = lat_rd_q;
        lat_rw_d   = lat_rw_q;
        lat_size_d = lat_size_q;
        lat_uns_d  = lat_uns_q;
        lat_off_d  = lat_off_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    if (wb_sel != 2'd1) begin
                        rf_we_d    = reg_write && (rd_addr != '0);
                        rf_waddr_d = rd_addr;
                        rf_wdata_d = src_data;
                    end else if (mem_rvalid) begin
                        rf_we_d    = reg_write && (rd_addr != '0);
                        rf_waddr_d = rd_addr;
                        rf_wdata_d = load_ext(mem_rdata[31:0], load_size, load_unsigned,
                                              byte_off);
                    end else begin
                        lat_rd_d   = rd_addr;
                        lat_rw_d   = reg_write;
                        lat_size_d = load_size;
                        lat_uns_d  = load_unsigned;
                        lat_off_d  = byte_off;
                        cnt_d      = '0;
                        state_d    = StWait;
                    end
                end
            end
            StWait: begin
                if (flush) begin
                    // Abort drops any same-cycle response silently.
                    state_d = StIdle;
                end else if (mem_rvalid) begin
                    rf_we_d    = lat_rw_q && (lat_rd_q != '0);
                    rf_waddr_d = lat_rd_q;
                    rf_wdata_d = load_ext(mem_rdata[31:0], lat_size_q, lat_uns_q, lat_off_q);
                    state_d    = StIdle;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            lat_rd_q   <= '0;
            lat_rw_q   <= 1'b0;
            lat_size_q <= 2'd0;
            lat_uns_q  <= 1'b0;
            lat_off_q  <= 2'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_rd_q   <= lat_rd_d;
            lat_rw_q   <= lat_rw_d;
            lat_size_q <= lat_size_d;
            lat_uns_q  <= lat_uns_d;
            lat_off_q  <= lat_off_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign err      = err_q;
    assign stall    = (state_q == StWait);

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_wb_select_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  wb_sel;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] imm;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [1:0]  byte_off;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: one outstanding load at most.
    bit          m_busy = 0;
    int          m_waited;
    int          m_rd;
    bit          m_rw;
    int          m_size;
    bit          m_uns;
    int          m_off;
    bit          e_we, e_err, e_data;
    logic [31:0] e_waddr, e_wdata;

    wb_select_stage #(.W(32), .AW(5), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .wb_sel(wb_sel),
        .alu_result(alu_result), .pc_plus4(pc_plus4), .imm(imm), .rd_addr(rd_addr),
        .reg_write(reg_write), .load_size(load_size), .load_unsigned(load_unsigned),
        .byte_off(byte_off), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(logic [31:0] d, int size, bit uns, int off);
        longint v;
        int     nb;
        if (size == 0) begin
            v  = (d >> (8 * off)) & 32'hFF;
            nb = 8;
        end else if (size == 1) begin
            v  = (d >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
            nb = 16;
        end else begin
            v  = d;
            nb = 32;
        end
        if (!uns && nb < 32 && ((v >> (nb - 1)) & 1) == 1) v = v - (longint'(1) << nb);
        return 32'(v);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model with the inputs present at the coming edge.
    task automatic model_step();
        e_we = 0; e_err = 0; e_data = 0;
        if (rst) begin
            m_busy = 0; e_data = 1; e_waddr = 0; e_wdata = 0;
        end else if (!m_busy) begin
            if (in_valid && !flush) begin
                if (wb_sel != 1) begin
                    e_we    = reg_write && rd_addr != 0;
                    e_waddr = 32'(rd_addr);
                    e_wdata = (wb_sel == 0) ? alu_result : (wb_sel == 2) ? pc_plus4 : imm;
                end else if (mem_rvalid) begin
                    e_we    = reg_write && rd_addr != 0;
                    e_waddr = 32'(rd_addr);
                    e_wdata = ref_ext(mem_rdata, load_size, load_unsigned, byte_off);
                end else begin
                    m_busy = 1; m_waited = 0; m_rd = rd_addr; m_rw = reg_write;
                    m_size = load_size; m_uns = load_unsigned; m_off = byte_off;
                end
            end
            e_data = e_we;
        end else begin
            m_waited++;
            if (flush) begin
                m_busy = 0;
            end else if (mem_rvalid) begin
                e_we    = m_rw && m_rd != 0;
                e_waddr = 32'(m_rd);
                e_wdata = ref_ext(mem_rdata, m_size, m_uns, m_off);
                e_data  = e_we;
                m_busy  = 0;
            end else if (m_waited == TO) begin
                e_err  = 1;
                m_busy = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("err", 32'(err), 32'(e_err));
        chk("stall", 32'(stall), 32'(m_busy));
        if (e_data) begin
            chk("rf_waddr", 32'(rf_waddr), e_waddr);
            chk("rf_wdata", rf_wdata, e_wdata);
        end
    endtask

    task automatic clear_in();
        rst = 0; in_valid = 0; wb_sel = 0; alu_result = 0; pc_plus4 = 0; imm = 0;
        rd_addr = 0; reg_write = 0; load_size = 0; load_unsigned = 0; byte_off = 0;
        mem_rdata = 0; mem_rvalid = 0; flush = 0;
    endtask

    task automatic load_req(logic [4:0] rd, logic [1:0] size, logic uns, logic [1:0] off);
        clear_in();
        in_valid = 1; wb_sel = 1; rd_addr = rd; reg_write = 1;
        load_size = size; load_unsigned = uns; byte_off = off;
    endtask

    initial begin
        clear_in();
        rst = 1;
        tick();
        tick();
        chk("reset_wdata", rf_wdata, 32'h0);

        // ALU writeback
        clear_in();
        in_valid = 1; wb_sel = 0; alu_result = 32'h1234_5678; rd_addr = 5; reg_write = 1;
        pc_plus4 = 32'hAAAA_0004; imm = 32'h5555_0000;
        tick();
        chk("alu_const", rf_wdata, 32'h1234_5678);

        // Zero-wait loads, signed then unsigned
        load_req(7, 2'd0, 1'b0, 2'd0);
        mem_rvalid = 1; mem_rdata = 32'h0000_80FF;
        tick();
        chk("zw_signed", rf_wdata, 32'hFFFF_FFFF);
        load_unsigned = 1;
        tick();
        chk("zw_unsigned", rf_wdata, 32'h0000_00FF);

        // PC+4 and IMM sources
        clear_in();
        in_valid = 1; reg_write = 1; rd_addr = 31; pc_plus4 = 32'h0000_1004;
        imm = 32'hABCD_E000; wb_sel = 2;
        tick();
        wb_sel = 3;
        tick();

        // Three-cycle half load
        load_req(9, 2'd1, 1'b0, 2'd2);
        tick();
        clear_in();
        tick();
        mem_rvalid = 1; mem_rdata = 32'h8001_0000;
        tick();
        chk("half_wait", rf_wdata, 32'hFFFF_8001);
        clear_in();

        // Timeout: four stall cycles then a single err pulse
        load_req(12, 2'd2, 1'b0, 2'd0);
        tick();
        clear_in();
        for (int i = 0; i < 5; i++) tick();

        // Flush with same-cycle response in WAIT, then a normal ALU write
        load_req(13, 2'd0, 1'b1, 2'd3);
        tick();
        clear_in();
        flush = 1; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        clear_in();
        in_valid = 1; wb_sel = 0; alu_result = 32'h0BAD_F00D; rd_addr = 3; reg_write = 1;
        tick();

        // rd=0 never writes; reset mid-WAIT clears everything
        rd_addr = 0;
        tick();
        load_req(10, 2'd0, 1'b0, 2'd1);
        tick();
        clear_in();
        rst = 1;
        tick();
        chk("rst_waddr", 32'(rf_waddr), 32'h0);
        clear_in();
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            wb_sel        = 2'($urandom_range(0, 3));
            alu_result    = $urandom;
            pc_plus4      = $urandom;
            imm           = $urandom;
            rd_addr       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            reg_write     = ($urandom_range(0, 5) != 0);
            load_size     = 2'($urandom_range(0, 3));
            load_unsigned = 1'($urandom);
            byte_off      = 2'($urandom);
            mem_rdata     = $urandom;
            mem_rvalid    = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
